phv_merge: RTL and testbench

Downstream neighbour of the per-stage type-1 ALU array in the RMT action engine. Captures each accepted PHV, delays it to match the fixed ALU latency, and overwrites its container region with the ALU results. The completed PHV goes into a small output FIFO, which presents it to the next stage with a valid/ready handshake. Upstream admission is credit-based, so an in-flight PHV always has a FIFO slot.

---
 rtl/phv_merge.sv | 153 +++++++++++++++
 tb/tb_phv_merge.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phv_merge.sv
// phv_merge: delays each accepted PHV to line up with the type-1 ALU array,
// overlays the valid ALU lane results onto its containers and queues the
// merged PHV in a small output FIFO with credit-based upstream admission.
// Optional build macro PHV_MERGE_ERR_CNT_EN adds a saturating err_cnt output.
module phv_merge #(
  parameter int unsigned  STAGE      = 0,
  parameter int unsigned  C_NUM      = 8,
  parameter int unsigned  DATA_WIDTH = 48,
  parameter int unsigned  META_WIDTH = 256,
  parameter int unsigned  ALU_LAT    = 2,
  parameter int unsigned  FIFO_DEPTH = 4,
  localparam int unsigned PHV_WIDTH  = C_NUM * DATA_WIDTH + META_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PHV_WIDTH-1:0]          phv_in,
  input  logic                          phv_in_valid,
  output logic                          phv_in_ready,
  input  logic [C_NUM*DATA_WIDTH-1:0]   alu_container_in,
  input  logic [C_NUM-1:0]              alu_container_valid,
  output logic [PHV_WIDTH-1:0]          phv_out,
  output logic                          phv_out_valid,
  input  logic                          phv_out_ready,
  output logic                          err_misalign
`ifdef PHV_MERGE_ERR_CNT_EN
  ,
  output logic [15:0]                   err_cnt
`endif
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + ALU_LAT + 1);

  // Elaboration-time parameter sanity
  if (ALU_LAT < 1) begin : g_bad_lat
    $error("phv_merge stage %0d: ALU_LAT must be >= 1", STAGE);
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("phv_merge stage %0d: FIFO_DEPTH must be a power of 2 and >= 2", STAGE);
  end

  logic                 accept;
  logic                 dl_valid [ALU_LAT];
  logic [PHV_WIDTH-1:0] dl_phv   [ALU_LAT];
  logic                 merge_valid;
  logic [PHV_WIDTH-1:0] merge_phv;
  logic                 alu_any;
  logic                 alu_all;
  logic                 misalign;

  logic [PHV_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        fifo_count;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 push;
  logic                 pop;
  logic [CW-1:0]        inflight;

  assign accept = phv_in_valid && phv_in_ready;

  // Delay-line valid bits: slot 0 takes the accept, every slot shifts each cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ALU_LAT; k++) dl_valid[k] <= 1'b0;
    end else begin
      dl_valid[0] <= accept;
      for (int k = 1; k < ALU_LAT; k++) dl_valid[k] <= dl_valid[k-1];
    end
  end

  // Delay-line payload; qualified by dl_valid so it needs no reset
  always_ff @(posedge clk) begin
    if (accept) dl_phv[0] <= phv_in;
    for (int k = 1; k < ALU_LAT; k++) dl_phv[k] <= dl_phv[k-1];
  end

  assign merge_valid = dl_valid[ALU_LAT-1];

  // Overlay ALU lanes that report a valid result onto the delayed PHV
  always_comb begin
    merge_phv = dl_phv[ALU_LAT-1];
    for (int i = 0; i < C_NUM; i++) begin
      if (alu_container_valid[i]) begin
        merge_phv[PHV_WIDTH-1-i*DATA_WIDTH -: DATA_WIDTH] =
          alu_container_in[(C_NUM-i)*DATA_WIDTH-1 -: DATA_WIDTH];
      end
    end
  end

  // Misalignment: partial results on a live slot, or results with no slot
  always_comb begin
    alu_any  = |alu_container_valid;
    alu_all  = &alu_container_valid;
    misalign = (merge_valid && !alu_all) || (!merge_valid && alu_any);
  end

  // Credit accounting from registered state only
  always_comb begin
    inflight = '0;
    for (int k = 0; k < ALU_LAT; k++) inflight = inflight + CW'(dl_valid[k]);
  end

  assign fifo_count   = wr_ptr - rd_ptr;
  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign fifo_full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign phv_in_ready = (CW'(fifo_count) + inflight) < CW'(FIFO_DEPTH);

  assign push = merge_valid && !fifo_full;
  assign pop  = phv_out_valid && phv_out_ready;

  // FIFO pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // FIFO storage; entries are only visible while the FIFO is non-empty
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= merge_phv;
  end

  assign phv_out_valid = !fifo_empty;
  assign phv_out       = fifo_empty ? '0 : fifo_mem[rd_ptr[AW-1:0]];

  // Sticky misalignment flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_misalign <= 1'b0;
    end else if (misalign) begin
      err_misalign <= 1'b1;
    end
  end

`ifdef PHV_MERGE_ERR_CNT_EN
  // Saturating count of cycles with a misalignment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 16'd0;
    end else if (misalign && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_phv_merge.sv
// tb_phv_merge: scoreboard bench for phv_merge with a cycle-scheduled ALU model.
module tb_phv_merge;

  localparam int unsigned C_NUM   = 8;
  localparam int unsigned DW      = 48;
  localparam int unsigned MW      = 256;
  localparam int unsigned ALU_LAT = 2;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CW_BITS = C_NUM * DW;
  localparam int unsigned PHV_W   = CW_BITS + MW;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [PHV_W-1:0]     phv_in = '0;
  logic                 phv_in_valid = 1'b0;
  logic                 phv_in_ready;
  logic [CW_BITS-1:0]   alu_container_in = '0;
  logic [C_NUM-1:0]     alu_container_valid = '0;
  logic [PHV_W-1:0]     phv_out;
  logic                 phv_out_valid;
  logic                 phv_out_ready = 1'b1;
  logic                 err_misalign;
`ifdef PHV_MERGE_ERR_CNT_EN
  logic [15:0]          err_cnt;
`endif

  phv_merge #(
    .STAGE(0), .C_NUM(C_NUM), .DATA_WIDTH(DW), .META_WIDTH(MW),
    .ALU_LAT(ALU_LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .phv_in(phv_in),
    .phv_in_valid(phv_in_valid),
    .phv_in_ready(phv_in_ready),
    .alu_container_in(alu_container_in),
    .alu_container_valid(alu_container_valid),
    .phv_out(phv_out),
    .phv_out_valid(phv_out_valid),
    .phv_out_ready(phv_out_ready),
    .err_misalign(err_misalign)
`ifdef PHV_MERGE_ERR_CNT_EN
    ,
    .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int               checks = 0;
  int               errors = 0;
  int unsigned      cyc = 0;
  logic [C_NUM-1:0] sch_mask [64];
  logic [CW_BITS-1:0] sch_data [64];
  logic [C_NUM-1:0] cur_mask = '0;
  logic [CW_BITS-1:0] cur_data = '0;
  logic [PHV_W-1:0] exp_q [$];
  int               acc_cnt = 0;
  int               out_cnt = 0;
  int unsigned      first_out = 0;
  int unsigned      last_out = 0;
  logic             prev_hold = 1'b0;
  logic [PHV_W-1:0] prev_out = '0;

  task automatic chk(input string tag, input logic [PHV_W-1:0] got, input logic [PHV_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Containers base+1 .. base+C_NUM, given metadata
  function automatic logic [PHV_W-1:0] mk_phv(input logic [DW-1:0] base, input logic [MW-1:0] meta);
    logic [PHV_W-1:0] r;
    r = '0;
    r[MW-1:0] = meta;
    for (int i = 0; i < C_NUM; i++) r[PHV_W-1-i*DW -: DW] = base + DW'(i + 1);
    return r;
  endfunction

  // ALU lanes base+0 .. base+C_NUM-1
  function automatic logic [CW_BITS-1:0] mk_alu(input logic [DW-1:0] base);
    logic [CW_BITS-1:0] d;
    d = '0;
    for (int i = 0; i < C_NUM; i++) d[(C_NUM-i)*DW-1 -: DW] = base + DW'(i);
    return d;
  endfunction

  function automatic logic [PHV_W-1:0] merge_model(input logic [PHV_W-1:0] p,
                                                    input logic [C_NUM-1:0] m,
                                                    input logic [CW_BITS-1:0] d);
    logic [PHV_W-1:0] r;
    r = p;
    for (int i = 0; i < C_NUM; i++)
      if (m[i]) r[PHV_W-1-i*DW -: DW] = d[(C_NUM-i)*DW-1 -: DW];
    return r;
  endfunction

  // ALU model: replay scheduled results in their target cycle
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    alu_container_valid = sch_mask[cyc % 64];
    alu_container_in    = sch_data[cyc % 64];
    sch_mask[cyc % 64]  = '0;
  end

  // Monitor: schedule ALU results on accept, score outputs on pop
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_hold) begin
        chk("hold_valid", PHV_W'(phv_out_valid), PHV_W'(1));
        chk("hold_data", phv_out, prev_out);
      end
      if (phv_in_valid && phv_in_ready) begin
        exp_q.push_back(merge_model(phv_in, cur_mask, cur_data));
        sch_mask[(cyc + ALU_LAT) % 64] = cur_mask;
        sch_data[(cyc + ALU_LAT) % 64] = cur_data;
        acc_cnt++;
      end
      if (phv_out_valid && phv_out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", PHV_W'(phv_out_valid), PHV_W'(0));
        else chk("phv_out", phv_out, exp_q.pop_front());
        if (out_cnt == 0) first_out = cyc;
        last_out = cyc;
        out_cnt++;
      end
      prev_hold = phv_out_valid && !phv_out_ready;
      prev_out  = phv_out;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [PHV_W-1:0] p, input logic [C_NUM-1:0] m, input logic [CW_BITS-1:0] d);
    phv_in       = p;
    cur_mask     = m;
    cur_data     = d;
    phv_in_valid = 1'b1;
  endtask

  task automatic idle();
    phv_in_valid = 1'b0;
    cur_mask     = '0;
  endtask

  // Asynchronous reset pulse; outputs must clear while rst_n is still low
  task automatic reset_pulse();
    idle();
    rst_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      sch_mask[i] = '0;
      sch_data[i] = '0;
    end
    alu_container_valid = '0;
    alu_container_in    = '0;
    #2;
    chk("rst_out_valid", PHV_W'(phv_out_valid), PHV_W'(0));
    chk("rst_out", phv_out, PHV_W'(0));
    chk("rst_err", PHV_W'(err_misalign), PHV_W'(0));
    step();
    step();
    rst_n   = 1'b1;
    acc_cnt = 0;
    out_cnt = 0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
    chk("drain", PHV_W'(exp_q.size() == 0), PHV_W'(1));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      sch_mask[i] = '0;
      sch_data[i] = '0;
    end

    // Reset state
    phv_out_ready = 1'b1;
    reset_pulse();
    chk("rst_ready", PHV_W'(phv_in_ready), PHV_W'(1));

    // Single PHV, full lanes, latency ALU_LAT+1
    step();
    drive(mk_phv(48'h0, 256'hAB), '1, mk_alu(48'h10));
    step();
    idle();
    @(negedge clk) chk("lat_t1", PHV_W'(phv_out_valid), PHV_W'(0));
    step();
    @(negedge clk) chk("lat_t2", PHV_W'(phv_out_valid), PHV_W'(0));
    step();
    @(negedge clk) begin
      chk("lat_t3", PHV_W'(phv_out_valid), PHV_W'(1));
      chk("single_out", phv_out, mk_phv(48'hF, 256'hAB));
    end
    wait_drain();
    chk("single_err", PHV_W'(err_misalign), PHV_W'(0));

    // Partial lanes: only lane 0 from the ALU
    reset_pulse();
    step();
    drive(mk_phv(48'h0, 256'hAB), 8'b0000_0001, mk_alu(48'h10));
    step();
    idle();
    wait_drain();
    chk("partial_err", PHV_W'(err_misalign), PHV_W'(1));

    // Backpressure: only FIFO_DEPTH PHVs admitted
    reset_pulse();
    phv_out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      drive(mk_phv(DW'(k * 16), MW'(k + 1)), '1, mk_alu(DW'(k * 16 + 256)));
    end
    step();
    idle();
    for (int k = 0; k < 4; k++) step();
    chk("bp_accepted", PHV_W'(acc_cnt), PHV_W'(DEPTH));
    chk("bp_ready", PHV_W'(phv_in_ready), PHV_W'(0));
    chk("bp_valid", PHV_W'(phv_out_valid), PHV_W'(1));
    phv_out_ready = 1'b1;
    wait_drain();
    chk("bp_out_cnt", PHV_W'(out_cnt), PHV_W'(DEPTH));
    chk("bp_ready_back", PHV_W'(phv_in_ready), PHV_W'(1));
    chk("bp_err", PHV_W'(err_misalign), PHV_W'(0));

    // Stray ALU result with nothing in flight
    reset_pulse();
    step();
    sch_mask[(cyc + 1) % 64] = '1;
    sch_data[(cyc + 1) % 64] = mk_alu(48'h55);
    for (int k = 0; k < 4; k++) step();
    chk("stray_err", PHV_W'(err_misalign), PHV_W'(1));
    chk("stray_no_out", PHV_W'(out_cnt), PHV_W'(0));
    chk("stray_valid", PHV_W'(phv_out_valid), PHV_W'(0));
`ifdef PHV_MERGE_ERR_CNT_EN
    chk("stray_cnt", PHV_W'(err_cnt), PHV_W'(1));
`endif

    // Back-to-back streaming of 16 PHVs
    reset_pulse();
    phv_out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      chk("stream_ready", PHV_W'(phv_in_ready), PHV_W'(1));
      drive(mk_phv(DW'(k * 32), MW'(k * 3 + 7)), 8'hFF, mk_alu(DW'(k * 32 + 4096)));
    end
    step();
    idle();
    wait_drain();
    chk("stream_cnt", PHV_W'(out_cnt), PHV_W'(16));
    chk("stream_gapless", PHV_W'(last_out - first_out), PHV_W'(15));
    chk("stream_err", PHV_W'(err_misalign), PHV_W'(0));

    // Mid-operation reset with PHVs in both the delay line and the FIFO
    reset_pulse();
    phv_out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      drive(mk_phv(DW'(k * 8 + 100), MW'(k + 50)), '1, mk_alu(DW'(k * 8 + 900)));
    end
    step();
    idle();
    chk("mid_busy_valid", PHV_W'(phv_out_valid), PHV_W'(1));
    reset_pulse();
    phv_out_ready = 1'b1;
    for (int k = 0; k < 8; k++) step();
    chk("mid_no_stale", PHV_W'(out_cnt), PHV_W'(0));
    chk("mid_valid", PHV_W'(phv_out_valid), PHV_W'(0));
    chk("mid_err", PHV_W'(err_misalign), PHV_W'(0));
    chk("mid_ready", PHV_W'(phv_in_ready), PHV_W'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
